// File: rtl/data_memory.sv
// Data memory with fixed access latency and a BUSYWAIT handshake.
// Byte-addressed, little-endian, DEPTH_WORDS x 32-bit storage; upper address bits wrap.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for READ or WRITE; request is captured on the next edge
// BUSY  | latency counter running; access happens at the edge where it is 0
// DONE  | one-cycle completion slot, requests ignored, then back to IDLE
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  LOADSIGNAL,
    input  logic [1:0]  STORESIGNAL,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      load_q, load_d;
    logic [1:0]      store_q, store_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     load_val;
    logic [31:0]     wmask;
    logic [31:0]     wlane;
    logic            complete;

    // Only the word/byte index bits are kept; the rest of the address wraps away.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:AW+2];

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign complete = (state_q == S_BUSY) && (cnt_q == '0);

    // Combinational handshake: high as soon as a request appears in IDLE, forced low in reset.
    assign BUSYWAIT = RESETN && (((state_q == S_IDLE) && (READ || WRITE)) || (state_q == S_BUSY));
    assign READDATA = rdata_q;

    // Select and extend the loaded byte/half/word from the latched request.
    always_comb begin
        sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (load_q)
            3'd1:    load_val = {{24{sel_byte[7]}}, sel_byte};
            3'd2:    load_val = {{16{sel_half[15]}}, sel_half};
            3'd4:    load_val = {24'h000000, sel_byte};
            3'd5:    load_val = {16'h0000, sel_half};
            default: load_val = rd_word;
        endcase
    end

    // Byte-lane mask and replicated store data; STORESIGNAL 0 writes nothing.
    always_comb begin
        wmask = 32'h0000_0000;
        wlane = wdata_q;
        case (store_q)
            2'd1: begin
                wmask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                wlane = {4{wdata_q[7:0]}};
            end
            2'd2: begin
                wmask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wlane = {2{wdata_q[15:0]}};
            end
            2'd3: begin
                wmask = 32'hFFFF_FFFF;
                wlane = wdata_q;
            end
            default: begin
                wmask = 32'h0000_0000;
                wlane = wdata_q;
            end
        endcase
    end

    // Next-state logic: capture in IDLE, count down in BUSY, single DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        store_d = store_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (READ || WRITE) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                    addr_d  = ADDRESS[AW+1:0];
                    wdata_d = WRITEDATA;
                    load_d  = LOADSIGNAL;
                    store_d = STORESIGNAL;
                    wr_d    = WRITE;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = load_val;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and request registers; reset clears everything except the memory array.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage update at the completion edge; a reset forces IDLE so an interrupted store is dropped.
    always_ff @(posedge CLK) begin
        if (complete && wr_q) begin
            mem[word_idx] <= (rd_word & ~wmask) | (wlane & wmask);
        end
    end

endmodule
